// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: D-stage redirect controls, instruction-memory port and F/D register outputs.
// master = fetch_stage, slave = surrounding pipeline / instruction memory.
interface fetch_stage_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 5;

    logic            stall;
    logic [1:0]      npc_sel;
    logic [15:0]     d_imm16;
    logic [25:0]     d_instr_index;
    logic [XLEN-1:0] d_rs_value;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_instr;
    logic [XLEN-1:0] d_instr;
    logic [XLEN-1:0] d_pc;
    logic            d_valid;
    logic            d_exc;
    logic [EXC_W-1:0] d_exc_code;

    modport master (
        input  stall, npc_sel, d_imm16, d_instr_index, d_rs_value, i_instr,
        output i_addr, d_instr, d_pc, d_valid, d_exc, d_exc_code
    );

    modport slave (
        output stall, npc_sel, d_imm16, d_instr_index, d_rs_value, i_instr,
        input  i_addr, d_instr, d_pc, d_valid, d_exc, d_exc_code
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS-style fetch stage: PC register, next-PC selection and F/D pipeline register.
// Optional fetch address checking (AdEL) enabled by defining FETCH_ADDR_CHECK_EN.
module fetch_stage (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master fif
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 5;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
    localparam logic [XLEN-1:0] PC_STEP  = 32'h0000_0004;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    logic [XLEN-1:0] f_pc;
    logic [XLEN-1:0] d_pc_q;
    logic [XLEN-1:0] d_instr_q;
    logic            d_valid_q;

    logic [XLEN-1:0] seq_pc_c;
    logic [XLEN-1:0] br_off_c;
    logic [XLEN-1:0] br_target_c;
    logic [XLEN-1:0] j_target_c;
    logic [XLEN-1:0] next_pc_c;
    logic [XLEN-1:0] capture_instr_c;

    // Redirect targets are all relative to the instruction sitting in D, not F.
    always_comb begin
        seq_pc_c    = f_pc + PC_STEP;
        br_off_c    = {{14{fif.d_imm16[15]}}, fif.d_imm16, 2'b00};
        br_target_c = d_pc_q + PC_STEP + br_off_c;
        j_target_c  = {d_pc_q[31:28], fif.d_instr_index, 2'b00};
        next_pc_c   = seq_pc_c;
        case (fif.npc_sel)
            NPC_SEQ: next_pc_c = seq_pc_c;
            NPC_BR:  next_pc_c = br_target_c;
            NPC_J:   next_pc_c = j_target_c;
            NPC_JR:  next_pc_c = fif.d_rs_value;
            default: next_pc_c = seq_pc_c;
        endcase
    end

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic [XLEN-1:0]  IMEM_LO  = 32'h0000_3000;
    localparam logic [XLEN-1:0]  IMEM_HI  = 32'h0000_6FFC;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

    logic             fault_c;
    logic             d_exc_q;
    logic [EXC_W-1:0] d_exc_code_q;

    // A faulting fetch still occupies the D slot so the exception can be taken there.
    always_comb begin
        fault_c         = (f_pc[1:0] != 2'b00) || (f_pc < IMEM_LO) || (f_pc > IMEM_HI);
        capture_instr_c = fault_c ? '0 : fif.i_instr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_exc_q      <= 1'b0;
            d_exc_code_q <= '0;
        end else if (!fif.stall) begin
            d_exc_q      <= fault_c;
            d_exc_code_q <= fault_c ? EXC_ADEL : '0;
        end
    end

    assign fif.d_exc      = d_exc_q;
    assign fif.d_exc_code = d_exc_code_q;
`else
    always_comb begin
        capture_instr_c = fif.i_instr;
    end

    assign fif.d_exc      = 1'b0;
    assign fif.d_exc_code = '0;
`endif

    // Delay slot is never squashed: the F/D capture ignores npc_sel entirely.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc      <= RESET_PC;
            d_instr_q <= '0;
            d_pc_q    <= RESET_PC;
            d_valid_q <= 1'b0;
        end else if (!fif.stall) begin
            f_pc      <= next_pc_c;
            d_instr_q <= capture_instr_c;
            d_pc_q    <= f_pc;
            d_valid_q <= 1'b1;
        end
    end

    assign fif.i_addr  = f_pc;
    assign fif.d_instr = d_instr_q;
    assign fif.d_pc    = d_pc_q;
    assign fif.d_valid = d_valid_q;
endmodule
